noc_input_fifo_buffer: RTL
==========================

// Module: noc_input_fifo_buffer
// PURPOSE
//  Parametrised router input-channel buffer: a DEPTH-entry FIFO of DATA_W-bit flits
//  that replaces the single-register input stage. Sits between the upstream link and
//  the router arbiter. Raises request for the head flit and flags local delivery
//  (to_pe) when the head's hop field is zero. Presents the head with the hop field
//  pre-decremented for forwarding. Exposes backpressure (ready) and occupancy.
// PARAMETERS
//  DATA_W   64  flit width in bits
//  DEPTH    4   FIFO entries; power of 2, >=2
//  HOP_MSB  55  MSB of hop-count field inside flit
//  HOP_LSB  48  LSB of hop-count field inside flit
// PORTS
//  clk       in   1                  clock, rising edge
//  reset     in   1                  synchronous, active-high
//  di        in   DATA_W             incoming flit
//  we        in   1                  write strobe from upstream link
//  ready     out  1                  buffer can accept a write this cycle (= !full)
//  grant     in   1                  arbiter grant; pops head at clock edge
//  packet    out  DATA_W             head flit, hop field adjusted (see below)
//  request   out  1                  head flit valid (= !empty)
//  to_pe     out  1                  head valid and head hop field == 0
//  count     out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  overflow  out  1                  sticky: a write arrived while full
// BEHAVIOUR
//  - Reset (sync, priority over all): rd/wr ptrs=0, count=0, overflow=0;
//    request=0, to_pe=0, packet=0, ready=1 in the same cycle reset is sampled.
//  - Push: at posedge, if we && ready && |di: store di at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  - Null flit: we with di==0 is discarded, no state change (zero flit = idle link).
//  - Write while full: flit dropped, overflow<=1 (held until reset). ready is computed
//    from the current count only; a same-cycle grant does NOT make room for that write.
//  - Pop: at posedge, if grant && request: rd_ptr++ (wraps). grant while empty ignored.
//  - Simultaneous push+pop (not full, not empty): both occur, count unchanged.
//  - count: +1 on push only, -1 on pop only, unchanged on both/neither.
//  - Latency: flit written at edge N is visible as head (request=1) after edge N if
//    FIFO was empty; no combinational path from we/di to request/packet.
//  - Outputs are combinational from registered state (ptrs, storage, count):
//    request = (count!=0); ready = (count!=DEPTH);
//    to_pe = request && (head[HOP_MSB:HOP_LSB]==0);
//    packet = 0 when empty; else head with hop field = hop-1 when hop!=0,
//    hop field unchanged (0) when to_pe; all other bits passed through.
//  - Hop decrement is modulo-free: hop==0 never decremented, so no underflow.
//  - Order: strict FIFO; no reordering, no bypass.
//  - Reset mid-operation flushes all contents; stored data need not be cleared.
// TESTING
//  1 reset, then we=1 di=64'h0003_0000_0000_00AA one cycle -> next cycle request=1,
//    to_pe=0, packet=64'h0002_0000_0000_00AA, count=1.
//  2 write di with [55:48]=8'h00, low byte 8'h55 -> request=1, to_pe=1, hop stays 0;
//    grant=1 one cycle -> request=0, packet=0, count=0.
//  3 DEPTH=4: write 4 flits 1..4 (hop=1), ready=0; 5th write -> dropped, overflow=1;
//    grant x4 -> heads 1,2,3,4 in order; count 4->0.
//  4 full FIFO, we=1 and grant=1 same cycle -> pop occurs, write dropped, overflow=1,
//    count=3. Half-full FIFO, we+grant same cycle -> count unchanged, order kept.
//  5 we=1 di=0 on empty FIFO -> request stays 0, count=0; grant on empty -> no change.
//  6 fill 3 entries, assert reset one cycle -> count=0, request=0, overflow=0, ready=1;
//    then 2*DEPTH push/pop pairs checks pointer wrap with data in order.

Source files
------------

// File: rtl/noc_input_fifo_buffer.sv
// Router input-channel buffer: DEPTH-deep flit FIFO with head request, local-delivery flag and hop pre-decrement.
// Built on a generic synchronous FIFO (also used elsewhere for plain flit queues).

// Generic synchronous FIFO, power-of-2 depth, sync active-high reset.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; callers gate on full/empty.
module fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// Input-channel buffer between upstream link and router arbiter.
// Latency: flit written at edge N is the head after edge N (no we/di -> request/packet path).
// Backpressure: ready = !full from current occupancy; writes while full are dropped and flagged in sticky overflow.
module noc_input_fifo_buffer #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int HOP_MSB = 55,
  parameter int HOP_LSB = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        di,
  input  logic                     we,
  output logic                     ready,
  input  logic                     grant,
  output logic [DATA_W-1:0]        packet,
  output logic                     request,
  output logic                     to_pe,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

  logic [DATA_W-1:0] head_dat;
  logic [HOP_W-1:0]  head_hop;
  logic              hop_zero;
  logic              flit_vld;
  logic              push_vld;
  logic              pop_vld;
  logic              full;
  logic              empty;

  // An all-zero flit is the idle-link pattern, never a real flit.
  assign flit_vld = we && (|di);
  assign push_vld = flit_vld && !full;
  assign pop_vld  = grant && !empty;

  fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_vld),
    .pop   (pop_vld),
    .din   (di),
    .dout  (head_dat),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset)                 overflow <= 1'b0;
    else if (flit_vld && full) overflow <= 1'b1;
  end

  assign head_hop = head_dat[HOP_MSB:HOP_LSB];
  assign hop_zero = (head_hop == '0);

  // Handshake outputs are forced to their idle values while reset is sampled.
  assign request = !reset && !empty;
  assign ready   = reset || !full;
  assign to_pe   = request && hop_zero;

  always_comb begin
    packet = '0;
    if (request) begin
      packet = head_dat;
      if (!hop_zero) packet[HOP_MSB:HOP_LSB] = head_hop - HOP_W'(1);
    end
  end

endmodule
